// File: rtl/fsm_mealy_det_if.sv
// Serial-bit detector bus: qualified bit stream and clear in, hit strobe/count/debug state out.
// The master modport drives the stream; the slave modport is the detector.
`timescale 1ns/1ps
interface fsm_mealy_det_if #(
    parameter int CNT_W = 8
);
    logic             clr;
    logic             in_vld;
    logic             in_bit;
    logic             hit;
    logic [CNT_W-1:0] hit_cnt;
    logic [1:0]       state_o;

    modport master (
        output clr, in_vld, in_bit,
        input  hit, hit_cnt, state_o
    );

    modport slave (
        input  clr, in_vld, in_bit,
        output hit, hit_cnt, state_o
    );
endinterface

// File: rtl/fsm_mealy_det.sv
// Mealy 1011 detector with saturating hit count; hit is 0-cycle combinational, or 1-cycle registered
// with FSM_MEALY_DET_REG_OUT_EN; no backpressure, one bit consumed per in_vld cycle.
`timescale 1ns/1ps
module fsm_mealy_det #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    fsm_mealy_det_if.slave    bus
);
    localparam logic [1:0] S0   = 2'd0;
    localparam logic [1:0] S1   = 2'd1;
    localparam logic [1:0] S10  = 2'd2;
    localparam logic [1:0] S101 = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_det;
    logic             w_sat;

    assign w_det = (r_state == S101) && bus.in_vld && bus.in_bit && !bus.clr;
    assign w_sat = &r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.clr) begin
            w_next = S0;
        end else if (bus.in_vld) begin
            case (r_state)
                S0:      w_next = bus.in_bit ? S1 : S0;
                S1:      w_next = bus.in_bit ? S1 : S10;
                S10:     w_next = bus.in_bit ? S101 : S0;
                // A completed match keeps its trailing 1 as a new prefix only when overlapping
                S101:    w_next = bus.in_bit ? ((OVERLAP != 0) ? S1 : S0) : S10;
                default: w_next = S0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.clr) begin
            r_cnt <= '0;
        end else if (w_det && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef FSM_MEALY_DET_REG_OUT_EN
    logic r_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_det;
        end
    end

    assign bus.hit = r_hit;
`else
    assign bus.hit = w_det;
`endif

    assign bus.hit_cnt = r_cnt;
    assign bus.state_o = r_state;
endmodule
